seg_display_ctrl: RTL and testbench
===================================

// Module: seg_display_ctrl
// PURPOSE
//  Downstream consumer of the clock-divider outputs. Converts the binary game score to 4 BCD
//  digits and time-multiplexes them onto a 4-digit common-anode 7-segment display.
//  fast_clk sets the digit-scan rate; blink_clk blanks the whole display when blinking is enabled.
//  fast_clk and blink_clk are treated as data levels, never as clocks; all logic runs on clk.
// PARAMETERS
//  SCORE_W         14  width of score input (max representable value 16383)
//  MAX_SCORE       9999  score clamp value applied before conversion
//  LEAD_ZERO_BLANK 1   1 = blank leading zero digits (digit 0 always shown); 0 = show all zeros
// PORTS
//  clk          in   1        system clock (100 MHz)
//  rst          in   1        synchronous, active-high reset
//  fast_clk     in   1        divider output level; each rising edge advances the scan digit
//  blink_clk    in   1        divider output level; high = blank phase when blink_en=1
//  blink_en     in   1        1 = enable display blinking (e.g. game over)
//  score        in   SCORE_W  binary score, sampled only when score_valid=1 and state IDLE
//  score_valid  in   1        1-cycle load request
//  busy         out  1        1 while a conversion is in progress
//  an           out  4        anode enables, active low, one-hot-low while scanning
//  seg          out  7        segments {g,f,e,d,c,b,a}, active low
//  dp           out  1        decimal point, active low; held at 1 (off)
// BEHAVIOUR
//  Reset (synchronous, highest priority): an=4'b1111, seg=7'h7F, dp=1, busy=0, all digit regs=0,
//   scan index=0, sync flops=0, pending flag=0, FSM=IDLE. Reset mid-conversion aborts it; digit regs=0.
//  Input sync: fast_clk and blink_clk each pass a 2-flop synchroniser; fast_clk has a third flop
//   for edge detect. scan_tick = sync & ~prev (1 clk wide). Tick to an/seg change: 4 clk edges.
//  Scan: 2-bit index increments on scan_tick, wraps 3->0. an/seg/dp are registered; an=~(1<<idx).
//  Blank: if blink_en & blink_sync, an=4'b1111 (index keeps advancing). Leading-zero-blanked
//   digits force their an bit to 1.
//  Conversion FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: on score_valid, latch min(score, MAX_SCORE), clear BCD accumulator, busy<=1, go SHIFT.
//   SHIFT: 14 iterations of double-dabble (add 3 to any nibble >=5, then shift left 1),
//     one per clk; 4-bit counter; after 14th go DONE.
//   DONE: copy the 16-bit BCD result to the display digit regs in one cycle; busy<=0; go IDLE.
//   Latency: score_valid sampled at edge N -> digit regs updated at edge N+15; busy high N+1..N+15.
//  score_valid while busy: value stored in a 1-deep pending register (latest wins); when DONE
//   completes, FSM re-enters SHIFT with the pending value without returning through IDLE
//   (busy stays 1). Display never shows partially converted digits.
//  Clamp boundary: score=9999 -> 9,9,9,9; score=10000..16383 -> 9,9,9,9. score=0 -> only digit0 lit.
//  Decoder: hex 0-9 standard patterns; codes A-F (unreachable) -> 7'h7F (blank).
// STRUCTURE
//  Shared include seg_defs.vh: 7-seg patterns SEG_0..SEG_9, SEG_BLANK, FSM state encodings.
//  Sub-module bcd_converter (clk, rst, start, bin, busy, done, bcd[15:0]) holds the double-dabble FSM;
//  top holds sync/edge detect, pending register, scan counter, blanking and segment decoder.
// TESTING
//  1 reset: assert rst 3 clk mid-scan -> an=1111, seg=7F, busy=0 on first edge after rst.
//  2 load 1234: pulse score_valid -> busy 15 cycles; scan shows digits 4,3,2,1 on an 1110..0111.
//  3 clamp/zero: score=12000 -> 9999; score=0, LEAD_ZERO_BLANK=1 -> only an[0] low, seg=SEG_0.
//  4 back-to-back: 42 then 7 then 88 within busy -> display 42, then 88 (7 overwritten); no glitch.
//  5 blink: blink_en=1, toggle blink_clk -> an=1111 during high phase, scan index continues.
//  6 scan rate: fast_clk period 200 clk -> an rotates once per 200 clk, 3->0 wrap verified.

Source files
------------

// File: rtl/seg_display_ctrl_pkg.sv
// Shared definitions for the score display controller.
// Contents:
//   - Active-low 7-segment patterns {g,f,e,d,c,b,a}: SEG_0..SEG_9 and SEG_BLANK.
//   - Conversion FSM state encodings.
//   - Width of the binary value fed to the BCD converter.
//   - seg_decode: maps a BCD digit to its segment pattern.
//   - dabble_adjust: the add-3 step of double-dabble.
package seg_display_ctrl_pkg;

  localparam int unsigned BIN_W = 14;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Any nibble >= 5 gets +3 so that the following left shift carries correctly into the
  // next decimal digit.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_bcd_converter.sv
// Sequential binary-to-BCD converter using double-dabble, one bit per clock.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   start - load request; honoured in IDLE, and in DONE to chain a new conversion
//   bin   - binary value to convert (already clamped to <= 9999)
//   busy  - high from the cycle after start until the result has been presented
//   done  - high for the single cycle in which bcd holds the final result
//   bcd   - four BCD digits, digit 3 in [15:12]
module bcd_converter
  import seg_display_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [15:0]      adj;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    adj     = dabble_adjust(bcd_q);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        bcd_d = {adj[14:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BIN_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A queued request restarts straight away so busy never drops between results.
        if (start) begin
          state_d = ST_SHIFT;
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = (state_q == ST_DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Score display controller: clamps the binary score, converts it to four BCD digits and
// time-multiplexes them onto a 4-digit common-anode 7-segment display.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   fast_clk    - divider level; each rising edge advances the scanned digit
//   blink_clk   - divider level; high blanks the display while blink_en is set
//   blink_en    - enables blinking
//   score       - binary score, taken when score_valid is high
//   score_valid - single-cycle load request
//   busy        - conversion in progress
//   an          - anode enables, active low
//   seg         - segments {g,f,e,d,c,b,a}, active low
//   dp          - decimal point, active low, always off
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_W         = 14,
  parameter int unsigned MAX_SCORE       = 9999,
  parameter bit          LEAD_ZERO_BLANK = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fast_clk,
  input  logic               blink_clk,
  input  logic               blink_en,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  logic fast_s1_q, fast_s2_q, fast_prev_q;
  logic blink_s1_q, blink_s2_q;
  logic scan_tick;

  logic [SCORE_W-1:0] score_clamped;
  logic [BIN_W-1:0]   bin_in;
  logic               pend_q;
  logic [BIN_W-1:0]   pend_val_q;

  logic               conv_start;
  logic [BIN_W-1:0]   conv_bin;
  logic               conv_busy;
  logic               conv_done;
  logic [15:0]        conv_bcd;

  logic [15:0] digits_q;
  logic [1:0]  idx_q;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q;
  logic [3:0]  cur_digit;
  logic [3:0]  lz_blank;

  assign scan_tick = fast_s2_q & ~fast_prev_q;

  assign score_clamped = (score > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : score;
  assign bin_in        = BIN_W'(score_clamped);

  // In the DONE cycle a fresh request beats the pending one (latest wins).
  always_comb begin
    conv_start = conv_done ? (pend_q | score_valid) : (score_valid & ~conv_busy);
    conv_bin   = (conv_done & ~score_valid) ? pend_val_q : bin_in;
  end

  bcd_converter u_bcd_converter (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    cur_digit   = digits_q[{idx_q, 2'b00} +: 4];
    lz_blank[0] = 1'b0;
    lz_blank[1] = LEAD_ZERO_BLANK && (digits_q[15:4] == 12'd0);
    lz_blank[2] = LEAD_ZERO_BLANK && (digits_q[15:8] == 8'd0);
    lz_blank[3] = LEAD_ZERO_BLANK && (digits_q[15:12] == 4'd0);
    if ((blink_en && blink_s2_q) || lz_blank[idx_q]) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << idx_q);
    end
    seg_d = seg_decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fast_s1_q   <= 1'b0;
      fast_s2_q   <= 1'b0;
      fast_prev_q <= 1'b0;
      blink_s1_q  <= 1'b0;
      blink_s2_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      digits_q    <= '0;
      idx_q       <= '0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      fast_s1_q   <= fast_clk;
      fast_s2_q   <= fast_s1_q;
      fast_prev_q <= fast_s2_q;
      blink_s1_q  <= blink_clk;
      blink_s2_q  <= blink_s1_q;

      if (scan_tick) begin
        idx_q <= idx_q + 2'd1;
      end

      // The DONE cycle consumes whatever was pending, so the flag always clears there.
      if (conv_done) begin
        pend_q <= 1'b0;
      end else if (score_valid && conv_busy) begin
        pend_q     <= 1'b1;
        pend_val_q <= bin_in;
      end

      // Only complete results reach the display registers.
      if (conv_done) begin
        digits_q <= conv_bcd;
      end

      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= 1'b1;
    end
  end

  assign busy = conv_busy;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: expected display values and busy lengths are queued as loads
// are issued; two monitor processes pop and compare as the DUT presents them.
module tb_seg_display_ctrl;

  logic        clk         = 1'b0;
  logic        rst         = 1'b1;
  logic        fast_clk    = 1'b0;
  logic        blink_clk   = 1'b0;
  logic        blink_en    = 1'b0;
  logic [13:0] score       = '0;
  logic        score_valid = 1'b0;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks   = 0;
  int failures = 0;
  int fast_half = 2;
  int busy_cnt  = 0;

  logic [15:0] disp_q[$];
  int          busy_len_q[$];
  logic [15:0] cur_disp  = '0;
  logic [3:0]  seen      = '0;
  int          nchg      = 0;
  logic [15:0] last_push = '0;

  seg_display_ctrl #(
    .SCORE_W         (14),
    .MAX_SCORE       (9999),
    .LEAD_ZERO_BLANK (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fast_clk    (fast_clk),
    .blink_clk   (blink_clk),
    .blink_en    (blink_en),
    .score       (score),
    .score_valid (score_valid),
    .busy        (busy),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (fast_half) @(negedge clk);
      fast_clk = ~fast_clk;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [15:0] v);
    logic [3:0] m;
    m[0] = 1'b1;
    m[1] = (v[15:4] != 12'd0);
    m[2] = (v[15:8] != 8'd0);
    m[3] = (v[15:12] != 4'd0);
    return m;
  endfunction

  function automatic bit lit_ok(input logic [15:0] v, input int pos, input logic [6:0] s);
    logic [3:0] m;
    logic [3:0] d;
    m = exp_mask(v);
    d = v[pos*4 +: 4];
    return (m[pos] == 1'b1) && (s === exp_seg(d));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [13:0] v);
    @(negedge clk);
    score       = v;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
  endtask

  task automatic expect_load(input logic [13:0] v, input logic [15:0] disp, input int blen);
    busy_len_q.push_back(blen);
    if (disp != last_push) begin
      disp_q.push_back(disp);
      last_push = disp;
    end
    load(v);
  endtask

  task automatic wait_an_change(output int cyc);
    logic [3:0] p;
    p   = an;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (an === p && cyc < 1000);
    if (an === p) begin
      checks++;
      failures++;
      $display("FAIL an_timeout actual=%b required=change", an);
    end
  endtask

  // Busy scoreboard: each high interval is compared against the queued length.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else if (busy === 1'b1) begin
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        if (busy_len_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL busy_unexpected actual=%0d required=none", busy_cnt);
        end else begin
          check("busy_len", busy_cnt, busy_len_q.pop_front());
        end
        busy_cnt = 0;
      end
    end
  end

  // Display scoreboard: every newly lit digit must belong to the value on show or to the
  // next queued value, which then becomes the value on show.
  initial begin
    logic [3:0]  prev_an;
    logic [15:0] nxt;
    int          pos;
    prev_an = 4'hF;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_disp = '0;
        seen     = '0;
        nchg     = 0;
        prev_an  = 4'hF;
      end else if (an !== prev_an) begin
        prev_an = an;
        nchg++;
        if (an !== 4'hF) begin
          pos = -1;
          for (int i = 0; i < 4; i++) begin
            if (an == ~(4'b0001 << i)) pos = i;
          end
          nxt = (disp_q.size() > 0) ? disp_q[0] : 16'hxxxx;
          if (pos < 0) begin
            checks++;
            failures++;
            $display("FAIL an_onehot actual=%b required=one-low", an);
          end else if (lit_ok(cur_disp, pos, seg)) begin
            checks++;
            seen[pos] = 1'b1;
          end else if (disp_q.size() > 0 && lit_ok(nxt, pos, seg)) begin
            if (nchg >= 12) check("lit_mask", 32'(seen), 32'(exp_mask(cur_disp)));
            cur_disp = disp_q.pop_front();
            seen     = 4'b0001 << pos;
            nchg     = 0;
            checks++;
          end else begin
            checks++;
            failures++;
            $display("FAIL display actual=an %b seg %h required=value %h or %h",
                     an, seg, cur_disp, nxt);
          end
        end
      end
    end
  end

  initial begin
    int  c;
    int  bad;
    int  lit;
    bit  found;
    bit  wrap;
    logic [3:0] prev;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Load 1234
    expect_load(14'd1234, 16'h1234, 15);
    repeat (100) @(negedge clk);

    // Reset mid-scan
    rst = 1'b1;
    @(negedge clk);
    check("rst_an", 32'(an), 32'h0F);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dp", 32'(dp), 32'h1);
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    last_push = '0;
    @(negedge clk);
    check("rst_zero_an", 32'(an), 32'hE);
    check("rst_zero_seg", 32'(seg), 32'h40);
    repeat (60) @(negedge clk);

    // Clamp boundary
    expect_load(14'd9999, 16'h9999, 15);
    repeat (30) @(negedge clk);
    expect_load(14'd12000, 16'h9999, 15);
    repeat (30) @(negedge clk);
    expect_load(14'd16383, 16'h9999, 15);
    repeat (30) @(negedge clk);
    expect_load(14'd10000, 16'h9999, 15);
    repeat (60) @(negedge clk);

    // Blink: align to digit 0, blank for 40 clk, scan must keep counting underneath
    blink_en = 1'b1;
    found    = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      wait_an_change(c);
      if (an === 4'b1110) found = 1'b1;
    end
    check("blink_align", 32'(found), 32'h1);
    blink_clk = 1'b1;
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= 4 && an !== 4'hF) bad++;
    end
    check("blink_blank", bad, 0);
    blink_clk = 1'b0;
    repeat (5) @(negedge clk);
    check("blink_scan_continues", 32'(an), 32'h7);
    blink_en  = 1'b0;
    blink_clk = 1'b1;
    lit = 0;
    repeat (20) begin
      @(negedge clk);
      if (an !== 4'hF) lit++;
    end
    check("blink_en_gates", 32'(lit > 0), 32'h1);
    blink_clk = 1'b0;
    repeat (10) @(negedge clk);

    // Scan rate: 200 clk fast_clk period
    fast_half = 100;
    wait_an_change(c);
    wait_an_change(c);
    wrap = 1'b0;
    for (int k = 0; k < 5; k++) begin
      prev = an;
      wait_an_change(c);
      check("scan_period", c, 200);
      check("scan_order", 32'(an), 32'({prev[2:0], prev[3]}));
      if (prev === 4'b0111 && an === 4'b1110) wrap = 1'b1;
    end
    check("scan_wrap", 32'(wrap), 32'h1);
    fast_half = 2;
    repeat (20) @(negedge clk);

    // Zero: only digit 0 lit
    expect_load(14'd0, 16'h0000, 15);
    repeat (100) @(negedge clk);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (an !== 4'hF && an !== 4'b1110) bad++;
    end
    check("zero_only_digit0", bad, 0);

    // Back-to-back: 42, 7, 88 while busy -> 42 then 88, one busy interval
    busy_len_q.push_back(30);
    disp_q.push_back(16'h0042);
    disp_q.push_back(16'h0088);
    load(14'd42);
    load(14'd7);
    load(14'd88);
    repeat (150) @(negedge clk);

    check("final_value", 32'(cur_disp), 32'h0088);
    check("final_mask", 32'(seen), 32'(exp_mask(cur_disp)));
    check("disp_drained", disp_q.size(), 0);
    check("busy_drained", busy_len_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
